enc_frame_sched: RTL and testbench
==================================

// Module: enc_frame_sched
// PURPOSE
//  Round-robin frame scheduler in front of the serial (8,4) block encoder. Arbitrates NREQ
//  nibble-wide requesters, locks the grant for a whole frame and serialises nibbles MSB-first
//  onto the encoder's 1-bit input, aligned to the encoder's 4-bit input phase. Flags which
//  encoder nibble slots carry payload and marks frame boundaries for the OFDM mapper.
// PARAMETERS
//  NREQ       2   number of requesters (2..8)
//  FRAME_NIB  16  max payload nibbles per frame (1..255); frame closes early on req_last
//  GAP_NIB    1   zero-filled nibble slots after every payload nibble (0..3)
// PORTS
//  clk          in   1        clock
//  reset        in   1        asynchronous, active-high
//  req_valid    in   NREQ     requester i has a nibble
//  req_data     in   4*NREQ   nibble of requester i at [4i+3:4i]
//  req_last     in   NREQ     nibble of requester i is last of its frame
//  req_ready    out  NREQ     one-hot; nibble of granted requester taken when valid&ready
//  enc_in       out  1        serial bit to encoder input
//  enc_active   out  1        high for the 4 bits of a payload (or parity) nibble
//  grant_id     out  clog2(NREQ) requester owning the current frame
//  frame_start  out  1        1-cycle pulse, first bit of first nibble of a frame
//  frame_end    out  1        1-cycle pulse, cycle after last slot of a frame
//  busy         out  1        high in every state except IDLE
// BEHAVIOUR
//  - reset: state IDLE, phase=0, rr pointer=0, nib_cnt=0; all outputs 0, grant_id=0.
//  - phase: free-running 2-bit counter, +1 every cycle, wraps 3->0; slot boundary at phase 0.
//  - IDLE: enc_in=0. Any req_valid -> pick first valid index at or after rr pointer (wrap),
//    register grant_id, -> LOAD. No valid -> stay.
//  - LOAD: req_ready[grant_id]=1 (only output asserted). On valid: capture nibble and last,
//    nib_cnt+1; -> SHIFT if phase==3 else ALIGN. Other requesters ignored (frame lock).
//  - ALIGN: enc_in=0; -> SHIFT when phase==3.
//  - SHIFT: 4 cycles, phase 0..3; enc_in=nib[3],nib[2],nib[1],nib[0]; enc_active=1.
//    frame_start=1 on first SHIFT cycle of a frame only.
//  - GAP: GAP_NIB*4 cycles, enc_in=0, enc_active=0; skipped when GAP_NIB=0.
//  - After last SHIFT/GAP cycle: last captured OR nib_cnt==FRAME_NIB -> END, else -> LOAD.
//  - END: 1 cycle, frame_end=1, rr pointer=grant_id+1 (wrap to 0 past NREQ-1), nib_cnt=0,
//    -> IDLE.
//  - Latency: nibble accepted at phase p -> first bit emitted at next phase 0.
//  - req_valid dropping in LOAD: wait indefinitely in LOAD, enc_in=0 (zero slots, enc_active=0).
//  - req_last with nib_cnt<FRAME_NIB closes frame; nib_cnt reaching FRAME_NIB closes frame
//    even without last (next nibble starts a new arbitration).
//  - Simultaneous valid on all requesters: strict rotation, one frame each.
//  - Reset mid-frame: immediate abort, no frame_end, outputs to reset values.
// CONFIGURATION
//  ENC_SCHED_PARITY_EN defined: before END, one extra SHIFT slot (plus its GAP) carrying
//   XOR of all payload nibbles of the frame, enc_active=1; not counted in nib_cnt.
//  Undefined: no parity slot; END follows last payload slot directly.
// TESTING
//  1 reset; req0 sends 4'hA,4'h3(last) -> enc_in 1010 then 0011 in phase-aligned slots,
//    4 zero gap bits between, frame_start on first '1', frame_end once, grant_id=0.
//  2 req0,req1 valid together, 1 nibble each, last=1 -> frame req0 then req1, then req0.
//  3 FRAME_NIB=2, req1 streams 3 nibbles no last -> frame_end after 2nd, new frame_start 3rd.
//  4 nibble accepted at phase 1 -> 2 ALIGN cycles, first bit exactly at phase 0.
//  5 PARITY_EN, nibbles 4'h5,4'h6(last) -> extra slot 0011 with enc_active=1 before frame_end.
//  6 assert reset during SHIFT -> same cycle: busy=0, enc_active=0, no frame_end pulse.

Source files
------------

// File: rtl/enc_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : enc_frame_sched
//  Description : Round-robin frame scheduler feeding the serial (8,4) block
//                encoder. Locks a requester for a whole frame, serialises its
//                nibbles MSB-first in slots aligned to the encoder's 4-bit
//                input phase, inserts zero gap slots and marks frame bounds.
//  Options     : define ENC_SCHED_PARITY_EN to append an XOR parity nibble
//                slot at the end of every frame.
//  Revision    : 1.0  initial release
// ============================================================================
module enc_frame_sched #(
    parameter int NREQ      = 2,
    parameter int FRAME_NIB = 16,
    parameter int GAP_NIB   = 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NREQ-1:0]                            req_valid,
    input  logic [4*NREQ-1:0]                          req_data,
    input  logic [NREQ-1:0]                            req_last,
    output logic [NREQ-1:0]                            req_ready,
    output logic                                       enc_in,
    output logic                                       enc_active,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic                                       frame_start,
    output logic                                       frame_end,
    output logic                                       busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [7:0]    c_frame_nib = 8'(FRAME_NIB);
    localparam logic [1:0]    c_gap_last  = 2'((GAP_NIB > 0) ? (GAP_NIB - 1) : 0);
    localparam logic [GW-1:0] c_rr_max    = GW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ALIGN = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_after;

    logic [1:0]      r_phase;
    logic [GW-1:0]   r_rr;
    logic [GW-1:0]   r_grant;
    logic [3:0]      r_nib;
    logic            r_last;
    logic [7:0]      r_nib_cnt;
    logic            r_first;
    logic [1:0]      r_gap_cnt;

    logic [GW-1:0]   w_pick;
    logic [GW:0]     w_sum;
    logic            w_payload_done;
    logic            w_take;
    logic [3:0]      w_req_nib;

`ifdef ENC_SCHED_PARITY_EN
    logic [3:0]      r_parity;
    logic            r_par_sent;
`endif

    assign w_take         = (r_state == S_LOAD) && req_valid[r_grant];
    assign w_req_nib      = req_data[{r_grant, 2'b00} +: 4];
    assign w_payload_done = r_last || (r_nib_cnt == c_frame_nib);

    // Round-robin pick: first valid requester at or after the rr pointer.
    always_comb begin
        w_pick = r_rr;
        w_sum  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr} + (GW+1)'(k);
            if (w_sum >= (GW+1)'(NREQ)) begin
                w_sum = w_sum - (GW+1)'(NREQ);
            end
            if (req_valid[w_sum[GW-1:0]]) begin
                w_pick = w_sum[GW-1:0];
            end
        end
    end

    // Where to go once a payload (or parity) slot and its gap have been sent.
    always_comb begin
`ifdef ENC_SCHED_PARITY_EN
        if (r_par_sent) begin
            w_after = S_END;
        end else if (w_payload_done) begin
            w_after = S_SHIFT;
        end else begin
            w_after = S_LOAD;
        end
`else
        w_after = w_payload_done ? S_END : S_LOAD;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        w_next      = r_state;
        req_ready   = '0;
        enc_in      = 1'b0;
        enc_active  = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                req_ready[r_grant] = 1'b1;
                if (req_valid[r_grant]) begin
                    w_next = (r_phase == 2'd3) ? S_SHIFT : S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (r_phase == 2'd3) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                enc_in      = r_nib[~r_phase];
                enc_active  = 1'b1;
                frame_start = r_first;
                if (r_phase == 2'd3) begin
                    w_next = (GAP_NIB != 0) ? S_GAP : w_after;
                end
            end
            S_GAP: begin
                if ((r_phase == 2'd3) && (r_gap_cnt == c_gap_last)) begin
                    w_next = w_after;
                end
            end
            S_END: begin
                frame_end = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign grant_id = r_grant;
    assign busy     = (r_state != S_IDLE);

    // Phase counter, arbitration, nibble capture and frame bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase    <= '0;
            r_rr       <= '0;
            r_grant    <= '0;
            r_nib      <= '0;
            r_last     <= 1'b0;
            r_nib_cnt  <= '0;
            r_first    <= 1'b0;
            r_gap_cnt  <= '0;
`ifdef ENC_SCHED_PARITY_EN
            r_parity   <= '0;
            r_par_sent <= 1'b0;
`endif
        end else begin
            r_phase <= r_phase + 2'd1;

            // Gap slot counter only runs while inside the gap.
            if (r_state == S_GAP) begin
                if (r_phase == 2'd3) begin
                    r_gap_cnt <= r_gap_cnt + 2'd1;
                end
            end else begin
                r_gap_cnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_grant    <= w_pick;
                        r_first    <= 1'b1;
                        r_last     <= 1'b0;
`ifdef ENC_SCHED_PARITY_EN
                        r_parity   <= '0;
                        r_par_sent <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_take) begin
                        r_nib     <= w_req_nib;
                        r_last    <= req_last[r_grant];
                        r_nib_cnt <= r_nib_cnt + 8'd1;
`ifdef ENC_SCHED_PARITY_EN
                        r_parity  <= r_parity ^ w_req_nib;
`endif
                    end
                end
                S_SHIFT: begin
                    r_first <= 1'b0;
                end
                S_END: begin
                    r_rr      <= (r_grant == c_rr_max) ? '0 : (r_grant + GW'(1));
                    r_nib_cnt <= '0;
                end
                default: begin
                end
            endcase

`ifdef ENC_SCHED_PARITY_EN
            // Payload finished: reload the shifter with the frame parity.
            if (((r_state == S_SHIFT) || (r_state == S_GAP)) && (w_next == S_SHIFT)) begin
                r_nib      <= r_parity;
                r_par_sent <= 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enc_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enc_frame_sched
//  Description : Self-checking bench for enc_frame_sched (NREQ=2,
//                FRAME_NIB=16, GAP_NIB=1). Table-driven frames plus hand
//                sequences; a scoreboard holds the expected encoder slots.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_enc_frame_sched;

    localparam int NREQ      = 2;
    localparam int FRAME_NIB = 16;
    localparam int GAP_NIB   = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [4*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0] req_last = '0;
    logic [NREQ-1:0] req_ready;
    logic            enc_in;
    logic            enc_active;
    logic [0:0]      grant_id;
    logic            frame_start;
    logic            frame_end;
    logic            busy;

    enc_frame_sched #(
        .NREQ      (NREQ),
        .FRAME_NIB (FRAME_NIB),
        .GAP_NIB   (GAP_NIB)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .enc_in      (enc_in),
        .enc_active  (enc_active),
        .grant_id    (grant_id),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference slot phase: free-running 2-bit counter cleared by reset.
    logic [1:0] tb_phase;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tb_phase <= '0;
        else       tb_phase <= tb_phase + 2'd1;
    end

    typedef struct {
        logic [3:0] nib;
        logic       first;
        logic       endafter;
        int         rid;
    } exp_t;

    exp_t sbq[$];
    int   gseq[$];
    int   mcnt    = 0;
    logic [3:0] mpar = '0;
    int   mframes = 0;
    int   nends   = 0;
    logic [1:0] acc_phase = '0;

    // Expected slots for one accepted nibble.
    task automatic model_push(input int r, input logic [3:0] d, input logic l);
        exp_t e;
        logic closes;
        mcnt++;
        mpar   = mpar ^ d;
        closes = l || (mcnt == FRAME_NIB);
        e.nib = d; e.first = (mcnt == 1); e.rid = r; e.endafter = closes;
`ifdef ENC_SCHED_PARITY_EN
        e.endafter = 1'b0;
`endif
        sbq.push_back(e);
`ifdef ENC_SCHED_PARITY_EN
        if (closes) begin
            e.nib = mpar; e.first = 1'b0; e.endafter = 1'b1;
            sbq.push_back(e);
        end
`endif
        if (closes) begin
            mcnt = 0; mpar = '0; mframes++;
        end
    endtask

    task automatic send_nib(input int r, input logic [3:0] d, input logic l);
        bit done = 0;
        req_valid[r] = 1'b1;
        req_data[r*4 +: 4] = d;
        req_last[r] = l;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                model_push(r, d, l);
                acc_phase = tb_phase;
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: requester %0d got no ready, required ready", r);
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    task automatic wait_ends(input int n);
        for (int k = 0; k < 80 && nends < n; k++) @(negedge clk);
        check("frame_end_count", 32'(nends), 32'(n));
    endtask

    // Output monitor: reassembles slots and pops the scoreboard.
    int         bitcnt  = 0;
    logic [3:0] sh      = '0;
    logic       fs      = 1'b0;
    logic       pending = 1'b0;
    logic       endpend = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            bitcnt = 0; pending = 1'b0; endpend = 1'b0;
        end else begin
            if (pending && tb_phase == 2'd0) begin
                check("latency_first_bit", 32'(enc_active), 32'd1);
                pending = 1'b0;
            end
            if (|(req_valid & req_ready)) pending = 1'b1;
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (frame_start) gseq.push_back(int'(grant_id));
            if (enc_active) begin
                if (bitcnt == 0) begin
                    check("slot_align", 32'(tb_phase), 32'd0);
                    fs = frame_start;
                end else begin
                    check("frame_start_width", 32'(frame_start), 32'd0);
                end
                sh = {sh[2:0], enc_in};
                bitcnt++;
                if (bitcnt == 4) begin
                    bitcnt = 0;
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_underflow: got slot %0h expected no slot", sh);
                    end else begin
                        e = sbq.pop_front();
                        check("slot_bits", 32'(sh), 32'(e.nib));
                        check("frame_start", 32'(fs), 32'(e.first));
                        check("slot_grant", 32'(grant_id), 32'(e.rid));
                        endpend = e.endafter;
                    end
                end
            end else begin
                check("zero_fill", 32'(enc_in), 32'd0);
                check("stray_frame_start", 32'(frame_start), 32'd0);
            end
            if (frame_end) begin
                check("frame_end_expected", 32'(endpend), 32'd1);
                endpend = 1'b0;
                nends++;
            end
        end
    end

    typedef struct {
        int         rid;
        logic [3:0] data;
        logic       last;
        int         exp_grant;
        int         exp_ends;
    } vec_t;

    vec_t vecs[6];
    int   exp_g[4] = '{0, 1, 0, 1};
    int   n;

    initial begin
        vecs[0] = '{rid: 0, data: 4'hA, last: 1'b0, exp_grant: 0, exp_ends: 0};
        vecs[1] = '{rid: 0, data: 4'h3, last: 1'b1, exp_grant: 0, exp_ends: 1};
        vecs[2] = '{rid: 1, data: 4'hF, last: 1'b1, exp_grant: 1, exp_ends: 2};
        vecs[3] = '{rid: 0, data: 4'h5, last: 1'b1, exp_grant: 0, exp_ends: 3};
        vecs[4] = '{rid: 1, data: 4'h0, last: 1'b0, exp_grant: 1, exp_ends: 3};
        vecs[5] = '{rid: 1, data: 4'h9, last: 1'b1, exp_grant: 1, exp_ends: 4};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_enc_active", 32'(enc_active), 32'd0);
        check("rst_enc_in", 32'(enc_in), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_frame_end", 32'(frame_end), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            send_nib(vecs[i].rid, vecs[i].data, vecs[i].last);
            check("vec_grant", 32'(grant_id), 32'(vecs[i].exp_grant));
            check("vec_busy", 32'(busy), 32'd1);
            if (vecs[i].last) wait_ends(vecs[i].exp_ends);
            else check("vec_no_end", 32'(nends), 32'(vecs[i].exp_ends));
        end

        // Simultaneous requesters rotate one frame each.
        gseq.delete();
        fork
            send_nib(0, 4'h1, 1'b1);
            send_nib(1, 4'h2, 1'b1);
        join
        fork
            send_nib(0, 4'h4, 1'b1);
            send_nib(1, 4'h8, 1'b1);
        join
        wait_ends(8);
        check("rot_frames", 32'(gseq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gseq.size(); i++) check("rot_grant", 32'(gseq[i]), 32'(exp_g[i]));

        // Frame length cap: 17 nibbles without last split into 16 + 1.
        gseq.delete();
        for (int i = 0; i < FRAME_NIB + 1; i++) send_nib(1, 4'(i + 3), (i == FRAME_NIB));
        wait_ends(10);
        check("cap_frames", 32'(gseq.size()), 32'd2);

        // Nibble accepted at phase 1 -> two align cycles, first bit at phase 0.
        for (int k = 0; k < 8 && tb_phase != 2'd0; k++) begin
            @(posedge clk);
            #1;
        end
        send_nib(0, 4'hB, 1'b1);
        check("align_acc_phase", 32'(acc_phase), 32'd1);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (enc_active) break;
            n++;
        end
        check("align_cycles", 32'(n), 32'd2);
        check("align_phase0", 32'(tb_phase), 32'd0);
        wait_ends(11);

        // Two-nibble frame; with parity enabled a 4'h3 slot precedes frame_end.
        send_nib(0, 4'h5, 1'b0);
        send_nib(0, 4'h6, 1'b1);
        wait_ends(12);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        // Reset asserted during SHIFT aborts without frame_end.
        send_nib(1, 4'hC, 1'b1);
        for (int k = 0; k < 8 && !enc_active; k++) @(negedge clk);
        check("abort_in_shift", 32'(enc_active), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_enc_active", 32'(enc_active), 32'd0);
        check("abort_frame_end", 32'(frame_end), 32'd0);
        check("abort_grant", 32'(grant_id), 32'd0);
        repeat (3) @(negedge clk);
        sbq.delete();
        mcnt = 0; mpar = '0; mframes = nends;
        #2;
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_end", 32'(nends), 32'd12);
        check("abort_idle", 32'(busy), 32'd0);

        check("total_frames", 32'(nends), 32'(mframes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
